sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 115 +++++++++++
 tb/tb_sync_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead or registered read, almost-full/empty
// thresholds and live fill level. Define SYNC_FIFO_ERR_EN for sticky Overflow/Underflow.
module sync_fifo #(
  parameter int DataWidth      = 8,
  parameter int FifoDepth      = 32,
  parameter bit ShowAhead      = 1'b1,
  parameter int AlmostFullThr  = FifoDepth - 4,
  parameter int AlmostEmptyThr = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             Push,
  input  logic [DataWidth-1:0]             DataIn,
  output logic                             FifoFull,
  output logic                             AlmostFull,
  input  logic                             Deq,
  output logic                             DataValid,
  output logic [DataWidth-1:0]             DataOut,
  output logic                             FifoEmpty,
  output logic                             AlmostEmpty,
  output logic [$clog2(FifoDepth+1)-1:0]   Level,
  output logic                             Overflow,
  output logic                             Underflow
);

  localparam int AW = $clog2(FifoDepth);
  localparam int LW = $clog2(FifoDepth + 1);
  localparam logic [AW:0] DepthC = FifoDepth[AW:0];
  localparam logic [AW:0] AfThrC = AlmostFullThr[AW:0];
  localparam logic [AW:0] AeThrC = AlmostEmptyThr[AW:0];

  logic [DataWidth-1:0] r_mem [FifoDepth];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [AW:0]          w_level;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_acc;
  logic                 w_pop_acc;
  logic [DataWidth-1:0] w_head;

  // Extra pointer MSB distinguishes full from empty; the subtraction wraps naturally.
  assign w_level    = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_level == DepthC);
  assign w_empty    = (w_level == '0);
  assign w_push_acc = Push && !w_full;
  assign w_pop_acc  = Deq && !w_empty;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  assign Level       = LW'(w_level);
  assign FifoFull    = w_full;
  assign FifoEmpty   = w_empty;
  assign AlmostFull  = (w_level >= AfThrC);
  assign AlmostEmpty = (w_level <= AeThrC);

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr[AW-1:0]] <= DataIn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  generate
    if (ShowAhead) begin : g_show_ahead
      assign DataOut   = w_head;
      assign DataValid = !w_empty;
    end else begin : g_reg_read
      logic [DataWidth-1:0] r_data_p1;
      logic                 r_vld_p1;

      // p1: popped word registered for the cycle after the accepting edge
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld_p1  <= 1'b0;
          r_data_p1 <= '0;
        end else begin
          r_vld_p1 <= w_pop_acc;
          if (w_pop_acc) r_data_p1 <= w_head;
        end
      end

      assign DataOut   = r_data_p1;
      assign DataValid = r_vld_p1;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (Push && w_full) r_ovf <= 1'b1;
      if (Deq && w_empty) r_udf <= 1'b1;
    end
  end

  assign Overflow  = r_ovf;
  assign Underflow = r_udf;
`else
  assign Overflow  = 1'b0;
  assign Underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one show-ahead and one registered-read instance share
// stimulus and are compared against a queue-based reference model.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       deq = 1'b0;
  logic [7:0] din = '0;

  logic       a_full, a_af, a_vld, a_empty, a_ae, a_ovf, a_udf;
  logic [7:0] a_dout;
  logic [5:0] a_lvl;
  logic       b_full, b_af, b_vld, b_empty, b_ae, b_ovf, b_udf;
  logic [7:0] b_dout;
  logic [5:0] b_lvl;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DataWidth(8), .FifoDepth(32), .ShowAhead(1'b1)) u_sa (
    .clk(clk), .rst(rst), .Push(push), .DataIn(din), .FifoFull(a_full),
    .AlmostFull(a_af), .Deq(deq), .DataValid(a_vld), .DataOut(a_dout),
    .FifoEmpty(a_empty), .AlmostEmpty(a_ae), .Level(a_lvl),
    .Overflow(a_ovf), .Underflow(a_udf));

  sync_fifo #(.DataWidth(8), .FifoDepth(32), .ShowAhead(1'b0)) u_reg (
    .clk(clk), .rst(rst), .Push(push), .DataIn(din), .FifoFull(b_full),
    .AlmostFull(b_af), .Deq(deq), .DataValid(b_vld), .DataOut(b_dout),
    .FifoEmpty(b_empty), .AlmostEmpty(b_ae), .Level(b_lvl),
    .Overflow(b_ovf), .Underflow(b_udf));

  // Reference model: occupancy is the queue length.
  logic [7:0] q[$];
  bit         m_ovf, m_udf, m_vld0;
  logic [7:0] m_dout0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf = 0; m_udf = 0; m_vld0 = 0; m_dout0 = '0;
  endtask

  task automatic model_step(input bit p, input bit d, input logic [7:0] x);
    bit full, empty;
    full  = (q.size() == 32);
    empty = (q.size() == 0);
    if (p && full)  m_ovf = 1;
    if (d && empty) m_udf = 1;
    if (d && !empty) begin
      m_dout0 = q.pop_front();
      m_vld0  = 1;
    end else begin
      m_vld0 = 0;
    end
    if (p && !full) q.push_back(x);
  endtask

  task automatic check_all(input string tag);
    int  lvl;
    bit  eo, eu;
    lvl = q.size();
`ifdef SYNC_FIFO_ERR_EN
    eo = m_ovf; eu = m_udf;
`else
    eo = 0; eu = 0;
`endif
    chk({tag, ".a_lvl"}, a_lvl, lvl);
    chk({tag, ".a_full"}, a_full, lvl == 32);
    chk({tag, ".a_empty"}, a_empty, lvl == 0);
    chk({tag, ".a_af"}, a_af, lvl >= 28);
    chk({tag, ".a_ae"}, a_ae, lvl <= 4);
    chk({tag, ".a_vld"}, a_vld, lvl != 0);
    if (lvl != 0) chk({tag, ".a_dout"}, a_dout, q[0]);
    chk({tag, ".a_ovf"}, a_ovf, eo);
    chk({tag, ".a_udf"}, a_udf, eu);
    chk({tag, ".b_lvl"}, b_lvl, lvl);
    chk({tag, ".b_full"}, b_full, lvl == 32);
    chk({tag, ".b_empty"}, b_empty, lvl == 0);
    chk({tag, ".b_vld"}, b_vld, m_vld0);
    chk({tag, ".b_dout"}, b_dout, m_dout0);
    chk({tag, ".b_ovf"}, b_ovf, eo);
  endtask

  task automatic cyc(input bit p, input bit d, input logic [7:0] x, input string tag);
    push = p; deq = d; din = x;
    @(posedge clk);
    model_step(p, d, x);
    #1;
    push = 0; deq = 0;
    check_all(tag);
  endtask

  typedef struct {
    bit         push;
    bit         deq;
    logic [7:0] din;
    int         lvl;
    bit         vld;
    logic [7:0] dout;
  } vec_t;

  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 8'h1F};
    vt[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 8'h1F};
    vt[2] = '{1'b1, 1'b0, 8'h33, 3, 1'b0, 8'h1F};
    vt[3] = '{1'b0, 1'b1, 8'h00, 2, 1'b1, 8'h11};
    vt[4] = '{1'b0, 1'b0, 8'h00, 2, 1'b0, 8'h11};

    // Reset held for three edges
    model_clear();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check_all("reset");
    chk("reset.empty", a_empty, 1);
    chk("reset.level", a_lvl, 0);
    chk("reset.b_vld", b_vld, 0);
    chk("reset.b_dout", b_dout, 0);

    // Fill 0..31, then a dropped 33rd push
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 8'(i), "fill");
      if (i == 26) chk("fill.af_before", a_af, 0);
      if (i == 27) chk("fill.af_at28", a_af, 1);
      if (i == 30) chk("fill.full_early", a_full, 0);
    end
    chk("fill.full", a_full, 1);
    chk("fill.level32", a_lvl, 32);
    cyc(1, 0, 8'hAA, "ovf");
    chk("ovf.level", a_lvl, 32);
`ifdef SYNC_FIFO_ERR_EN
    chk("ovf.sticky", a_ovf, 1);
`endif

    // Drain in order with continuous Deq
    for (int i = 0; i < 32; i++) begin
      chk("drain.order", a_dout, i);
      cyc(0, 1, 8'h00, "drain");
    end
    chk("drain.empty", a_empty, 1);
    chk("drain.b_last", b_dout, 8'h1F);
    cyc(0, 1, 8'h00, "udf");
`ifdef SYNC_FIFO_ERR_EN
    chk("udf.sticky", a_udf, 1);
`endif

    // Registered-read vectors
    for (int i = 0; i < 5; i++) begin
      cyc(vt[i].push, vt[i].deq, vt[i].din, "vec");
      chk("vec.level", b_lvl, vt[i].lvl);
      chk("vec.b_vld", b_vld, vt[i].vld);
      chk("vec.b_dout", b_dout, vt[i].dout);
    end
    cyc(0, 1, 8'h00, "vec_drain");
    cyc(0, 1, 8'h00, "vec_drain");

    // Steady state: level held at 16 while both pointers wrap
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i), "preload");
    for (int k = 0; k < 100; k++) begin
      chk("steady.head", a_dout, 8'(k));
      cyc(1, 1, 8'(16 + k), "steady");
      chk("steady.level", a_lvl, 16);
    end

    // Randomised traffic in phases biased toward full and toward empty
    for (int ph = 0; ph < 4; ph++) begin
      int pp;
      pp = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 65 : 50;
      for (int k = 0; k < 100; k++) begin
        bit p, d;
        p = ($urandom_range(99) < pp);
        d = ($urandom_range(99) >= pp) || ($urandom_range(9) == 0);
        cyc(p, d, 8'($urandom), "rand");
      end
    end

    // Asynchronous reset mid-operation at level 10
    while (q.size() > 10) cyc(0, 1, 8'h00, "to10");
    while (q.size() < 10) cyc(1, 0, 8'($urandom), "to10");
    chk("mid.level10", a_lvl, 10);
    #2 rst = 1;
    #1;
    chk("mid.level0", a_lvl, 0);
    chk("mid.empty", a_empty, 1);
    chk("mid.b_lvl0", b_lvl, 0);
    chk("mid.b_vld", b_vld, 0);
    chk("mid.b_dout", b_dout, 0);
    rst = 0;
    model_clear();
    cyc(1, 0, 8'h5A, "post");
    chk("post.a_dout", a_dout, 8'h5A);
    cyc(0, 1, 8'h00, "post_pop");
    chk("post.b_dout", b_dout, 8'h5A);
    chk("post.b_vld", b_vld, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
